// File: rtl/tick_scheduler_pkg.sv
// rtl/tick_scheduler_pkg.sv - shared types and elaboration helpers for tick_scheduler
package tick_scheduler_pkg;

  // Upper bounds for the config request record. The top zero-extends its
  // parameterised ports into these fields.
  localparam int unsigned CFG_CH_W_MAX     = 16;
  localparam int unsigned CFG_PERIOD_W_MAX = 32;

  typedef struct packed {
    logic [CFG_CH_W_MAX-1:0]     ch;
    logic                        enable;
    logic [CFG_PERIOD_W_MAX-1:0] period;
  } cfg_req_t;

  // Number of system clocks per base tick; 0 flags an unusable setting.
  function automatic int unsigned calc_prescale(input int unsigned src_hz,
                                                input int unsigned base_hz);
    return (base_hz == 0) ? 0 : src_hz / base_hz;
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_idx_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one periodic tick channel with glitch-free period update
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   base_tick    shared prescaler strobe; the channel counts one step per strobe
//   wr_en        accepted config write addressed to this channel
//   wr_stop      the write is a stop (enable low or zero period)
//   wr_period    requested period in base ticks
//   tick         registered one-cycle strobe, one cycle after the wrapping base tick
//   active       channel running
//   pend_valid   a period update is waiting for the next wrap
module tick_channel import tick_scheduler_pkg::*; #(
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    base_tick,
  input  logic                    wr_en,
  input  logic                    wr_stop,
  input  logic [PERIOD_WIDTH-1:0] wr_period,
  output logic                    tick,
  output logic                    active,
  output logic                    pend_valid
);

  logic                    active_q, active_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] count_q, count_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [PERIOD_WIDTH-1:0] pend_period_q, pend_period_d;
  logic                    tick_q, tick_d;
  logic                    wrap;

  // period is never 0 while active, so period-1 cannot underflow here.
  assign wrap = active_q && base_tick && (count_q == (period_q - PERIOD_WIDTH'(1)));

  always_comb begin
    active_d      = active_q;
    period_d      = period_q;
    count_d       = count_q;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    tick_d        = 1'b0;

    if (active_q && base_tick) begin
      if (wrap) begin
        count_d = '0;
        tick_d  = 1'b1;
        // A pending period only lands on a boundary, so no period is cut short.
        if (pend_valid_q) begin
          period_d     = pend_period_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        count_d = count_q + PERIOD_WIDTH'(1);
      end
    end

    // A write overrides the counting step above: a stop also swallows a
    // coincident wrap, and an update in a wrap cycle queues for the next one.
    if (wr_en) begin
      if (wr_stop) begin
        active_d     = 1'b0;
        count_d      = '0;
        pend_valid_d = 1'b0;
        tick_d       = 1'b0;
      end else if (!active_q) begin
        active_d = 1'b1;
        period_d = wr_period;
        count_d  = '0;
      end else begin
        pend_valid_d  = 1'b1;
        pend_period_d = wr_period;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      period_q      <= '0;
      count_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      tick_q        <= 1'b0;
    end else begin
      active_q      <= active_d;
      period_q      <= period_d;
      count_q       <= count_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      tick_q        <= tick_d;
    end
  end

  assign tick       = tick_q;
  assign active     = active_q;
  assign pend_valid = pend_valid_q;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel periodic tick generator with shared prescaler
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_valid/ready     config handshake; transfer when both high
//   cfg_ch              target channel; out-of-range values are accepted and ignored
//   cfg_enable          1 = start or re-periodise, 0 = stop
//   cfg_period          period in base ticks; 0 acts as a stop
//   base_tick           registered prescaler strobe, one cycle every PRESCALE clocks
//   tick[NUM_CH]        per-channel one-cycle strobes
//   active[NUM_CH]      per-channel running flags
module tick_scheduler import tick_scheduler_pkg::*; #(
  parameter  int unsigned SRC_FREQ_HZ  = 100_000_000,
  parameter  int unsigned BASE_FREQ_HZ = 1_000_000,
  parameter  int unsigned NUM_CH       = 4,
  parameter  int unsigned PERIOD_WIDTH = 16,
  localparam int unsigned CH_W         = ch_idx_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_enable,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       active
);

  localparam int unsigned PRESCALE = calc_prescale(SRC_FREQ_HZ, BASE_FREQ_HZ);
  localparam int unsigned PS_W     = (PRESCALE >= 2) ? $clog2(PRESCALE) : 1;

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("tick_scheduler: SRC_FREQ_HZ / BASE_FREQ_HZ must be at least 2");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("tick_scheduler: NUM_CH must be at least 1");
  end
  if (PERIOD_WIDTH < 1 || PERIOD_WIDTH > CFG_PERIOD_W_MAX) begin : g_bad_period_w
    $error("tick_scheduler: PERIOD_WIDTH out of range");
  end
  if (CH_W > CFG_CH_W_MAX) begin : g_bad_ch_w
    $error("tick_scheduler: NUM_CH too large for cfg_req_t");
  end

  // Prescaler: free running, untouched by config traffic.
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  logic            base_tick_q, base_tick_d;

  always_comb begin
    ps_cnt_d    = ps_cnt_q + PS_W'(1);
    base_tick_d = 1'b0;
    if (ps_cnt_q == PS_W'(PRESCALE - 1)) begin
      ps_cnt_d    = '0;
      base_tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_q    <= '0;
      base_tick_q <= 1'b0;
    end else begin
      ps_cnt_q    <= ps_cnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign base_tick = base_tick_q;

  // Config decode.
  cfg_req_t                cfg_req;
  logic                    wr_stop;
  logic [PERIOD_WIDTH-1:0] wr_period;
  logic [NUM_CH-1:0]       wr_en;
  logic [NUM_CH-1:0]       pend_valid;
  logic                    pend_sel;

  always_comb begin
    cfg_req        = '0;
    cfg_req.ch     = CFG_CH_W_MAX'(cfg_ch);
    cfg_req.enable = cfg_enable;
    cfg_req.period = CFG_PERIOD_W_MAX'(cfg_period);
  end

  assign wr_stop   = !cfg_req.enable || (cfg_req.period == '0);
  assign wr_period = cfg_req.period[PERIOD_WIDTH-1:0];

  // Out-of-range channels match nothing: no pending flag, so always ready,
  // and no write strobe, so the request is silently dropped.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_req.ch == CFG_CH_W_MAX'(i)) pend_sel = pend_valid[i];
    end
  end

  // Combinational so that stops are never held off by a pending update.
  assign cfg_ready = !pend_sel || !cfg_req.enable;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = cfg_valid && cfg_ready && (cfg_req.ch == CFG_CH_W_MAX'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .base_tick (base_tick_q),
      .wr_en     (wr_en[g]),
      .wr_stop   (wr_stop),
      .wr_period (wr_period),
      .tick      (tick[g]),
      .active    (active[g]),
      .pend_valid(pend_valid[g])
    );
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel periodic tick generator: one shared prescaler derives a base tick from the system clock, and NUM_CH independent channels each emit a one-cycle `tick` strobe every programmable number of base ticks. Channels are started, stopped and re-periodised at runtime through a valid/ready config port, and period changes on a running channel apply glitch-free at the next period boundary. The block sits beside `clock_divider` and replaces derived clocks with clock-enable strobes for timers, UART baud and LED/PWM sequencing.

## Interface
- `SRC_FREQ_HZ`, default 100_000_000: input clock frequency in Hz.
- `BASE_FREQ_HZ`, default 1_000_000: base tick rate. `PRESCALE = SRC_FREQ_HZ / BASE_FREQ_HZ`, which must be at least 2 (elaboration error otherwise).
- `NUM_CH`, default 4: number of channels, at least 1.
- `PERIOD_WIDTH`, default 16: width of a channel period, counted in base ticks.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accept; the request transfers when `cfg_valid && cfg_ready`.
- `cfg_ch` in `$clog2(NUM_CH)` (min 1): target channel. Values of `NUM_CH` or above are accepted and ignored.
- `cfg_enable` in 1: 1 = run or update the period, 0 = stop.
- `cfg_period` in PERIOD_WIDTH: period P in base ticks.
- `base_tick` out 1: registered prescaler strobe.
- `tick` out NUM_CH: per-channel one-cycle strobes.
- `active` out NUM_CH: channel running.

## Operation
**Prescaler**
- Free-running counter over 0..PRESCALE-1.
- `base_tick` is high for one cycle per wrap.
- Config activity never resets the prescaler.

**Channel state**
- Per channel: `active`, `period`, `count`, `pend_valid`, `pend_period`.

**Accepted write, `cfg_enable=0`**
- Clear `active`, `count` and `pend_valid`.
- If a wrap happens in the same cycle, no `tick` is issued for it.

**Accepted write, `cfg_enable=1`, `cfg_period=0`**
- Treated exactly as a stop.

**Accepted write, `cfg_enable=1`, idle channel**
- `period` = P, `count` = 0, `active` = 1 on the next edge.

**Accepted write, `cfg_enable=1`, active channel**
- Store `pend_period` = P and set `pend_valid`.
- Applied at the channel's next wrap, when `period` takes the pending value and `pend_valid` clears.

**Counting (per `base_tick` while active)**
- If `count == period-1`: wrap, `count` = 0, `tick` pulses.
- Otherwise `count` increments.
- P=1 gives a tick on every base tick.
- The counter compares with `==` at full PERIOD_WIDTH. The maximum period is 2^PERIOD_WIDTH-1.

**Config handshake**
- `cfg_ready = !pend_valid[cfg_ch] || !cfg_enable`. It is combinational, so stops are never blocked.
- A second period update to the same channel stalls until the first has applied.

**Simultaneous events**
- A period update accepted in the same cycle as a wrap: the wrap uses the old period and the pending value applies at the following wrap.
- Writes to different channels are independent, one per cycle.

## Timing
**Reset (`rst_n` low)**
- All state clears asynchronously.
- `base_tick`, `tick`, `active` = 0. `cfg_ready` = 1.
- Reset asserted mid-period aborts all channels with no trailing tick.

**Base tick**
- `base_tick` first rises PRESCALE cycles after reset release, then repeats every PRESCALE cycles.

**Tick latency**
- `tick[i]` is registered: it rises one cycle after the `base_tick` cycle in which channel i wraps.
- With `active` set at edge E, the first tick follows the P-th `base_tick` after E.
- Steady state: one tick every P·PRESCALE cycles, each exactly one cycle wide.

**Config write latency**
- `active` reflects an accepted write one cycle after acceptance.

## Structure
- Package `tick_scheduler_pkg` holds:
  - the `cfg_req_t` struct (ch, enable, period);
  - the `PRESCALE` derivation function;
  - channel-index width helper.
- Sub-module `tick_channel`: one instance per channel, generated. It holds active/period/count/pending and the wrap logic. Inputs are `base_tick` and a decoded write strobe; outputs are `tick`, `active` and `pend_valid`.
- The top level holds the prescaler, the channel decode and the `cfg_ready` mux.

## Test plan
Unless stated, the bench uses SRC_FREQ_HZ=8, BASE_FREQ_HZ=2 (PRESCALE=4), NUM_CH=4 and PERIOD_WIDTH=8.
1. Reset release, no config → `base_tick` at cycles 4, 8, 12, …; `tick` and `active` stay 0.
2. Enable ch0 with P=3 → `active[0]` high the next cycle; `tick[0]` every 12 cycles, one cycle wide; other channels silent.
3. ch1 running at P=2, then write P=5 mid-period → the current period completes at 2. From then on the interval is 20 cycles. A second P=5 write to ch1 before the update applies sees `cfg_ready=0`.
4. Stop ch2 in its wrap cycle (P=1) → no `tick[2]`; `active[2]` falls next cycle; a stop is accepted even with an update pending.
5. Write `cfg_enable=1`, P=0 to running ch3 → ch3 stops. Write P=255 → ticks every 1020 cycles.
6. Pulse `rst_n` low mid-period with all channels active → all outputs 0 immediately. After release, `base_tick` resumes with period 4 and no channel ticks.
